// File: rtl/fp_sqrt_pkg.sv
// rtl/fp_sqrt_pkg.sv - shared types, constants and special-case classifier for fp_sqrt_iter
// Contents:
//   fp_sqrt_state_t   sequencer states
//   FP_* constants    IEEE-754 single-precision encodings used by the datapath
//   fp_special_t      special-case decision (hit flag + canned result)
//   classify_special  decides at accept time whether the input bypasses Newton-Raphson
package fp_sqrt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SQ,
      ST_HX,
      ST_SUB,
      ST_UPD,
      ST_FIN,
      ST_DONE
   } fp_sqrt_state_t;

   localparam logic [31:0] FP_THREE_HALVES = 32'h3fc00000;
   localparam logic [31:0] FP_QNAN         = 32'h7fc00000;
   localparam logic [31:0] FP_PINF         = 32'h7f800000;
   localparam logic [31:0] FP_ZERO         = 32'h00000000;

   typedef struct packed {
      logic        hit;
      logic [31:0] value;
   } fp_special_t;

   // sqrt_mode: 0 = inverse sqrt, 1 = sqrt.
   // Zero and denormal inputs are treated alike (exponent field 0), so -0 maps
   // like +0. Any other negative input, including -inf, yields a quiet NaN.
   function automatic fp_special_t classify_special(input logic [31:0] x,
                                                    input logic        sqrt_mode);
      fp_special_t s;
      s.hit   = 1'b1;
      s.value = FP_QNAN;
      if (x[30:23] == 8'd0) begin
         s.value = sqrt_mode ? FP_ZERO : FP_PINF;
      end else if (x[31]) begin
         s.value = FP_QNAN;
      end else if (x[30:23] == 8'hff) begin
         if (x[22:0] != 23'd0) begin
            s.value = FP_QNAN;
         end else begin
            s.value = sqrt_mode ? FP_PINF : FP_ZERO;
         end
      end else begin
         s.hit   = 1'b0;
         s.value = FP_ZERO;
      end
      return s;
   endfunction

endpackage

// File: rtl/fp_mul_trunc.sv
// rtl/fp_mul_trunc.sv - combinational truncating single-precision multiplier
// Ports:
//   a_i  in  32  operand a (IEEE-754 single)
//   b_i  in  32  operand b (IEEE-754 single)
//   p_o  out 32  a*b, truncated, flushed to +0 on zero/denormal operands or underflow
module fp_mul_trunc
   import fp_sqrt_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] p_o
);

   logic [22:0] sig_a;
   logic [22:0] sig_b;
   logic [45:0] prod;
   logic [9:0]  exp_sum;
   logic [7:0]  exp_res;
   logic [22:0] frac_res;
   logic        unused_bits;

   // Significands drop the lowest fraction bit so the product fits 23x23 -> 46 bits.
   // The product is in 2.44 fixed point; prod[45] set means the value is >= 2.
   always_comb begin
      sig_a   = {1'b1, a_i[22:1]};
      sig_b   = {1'b1, b_i[22:1]};
      prod    = sig_a * sig_b;
      exp_sum = {2'b00, a_i[30:23]} + {2'b00, b_i[30:23]};
      if (prod[45]) begin
         exp_res  = exp_sum[7:0] - 8'd126;
         frac_res = prod[44:22];
      end else begin
         exp_res  = exp_sum[7:0] - 8'd127;
         frac_res = prod[43:21];
      end
      if ((a_i[30:23] == 8'd0) || (b_i[30:23] == 8'd0) || (exp_sum < 10'd128)) begin
         p_o = FP_ZERO;
      end else begin
         p_o = {a_i[31] ^ b_i[31], exp_res, frac_res};
      end
   end

   assign unused_bits = ^{prod[20:0], a_i[0], b_i[0]};

endmodule

// File: rtl/fp_sqrt_iter.sv
// rtl/fp_sqrt_iter.sv - iterative sqrt / inverse-sqrt unit (magic seed + Newton-Raphson)
// Parameters:
//   NUM_ITER     Newton iterations per operation (1..4)
//   MAGIC        seed constant
// Ports:
//   clk          in  1   clock, rising edge
//   rst          in  1   synchronous active-high reset
//   in_valid     in  1   request valid
//   in_ready     out 1   unit idle and able to accept
//   opa          in  32  operand x
//   mode         in  1   0 = inverse sqrt, 1 = sqrt
//   out_valid    out 1   result valid, held until out_ready
//   out_ready    in  1   consumer accepts result
//   result       out 32  1/sqrt(x) or sqrt(x)
//   out_special  out 1   result came from the special-case path
module fp_sqrt_iter
   import fp_sqrt_pkg::*;
#(
   parameter int          NUM_ITER = 1,
   parameter logic [31:0] MAGIC    = 32'h5f3759df
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] opa,
   input  logic        mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        out_special
);

   localparam int          IW       = $clog2(NUM_ITER + 1);
   localparam logic [IW-1:0] ITER_MAX = IW'(NUM_ITER);
   localparam logic [7:0]  EA       = FP_THREE_HALVES[30:23];

   fp_sqrt_state_t state_q;
   logic [31:0]    x_q;
   logic [31:0]    xh_q;
   logic [31:0]    y_q;
   logic [31:0]    t_q;
   logic           mode_q;
   logic [IW-1:0]  iter_q;
   logic [IW-1:0]  iter_d;
   logic           in_ready_q;
   logic           out_valid_q;
   logic [31:0]    result_q;
   logic           out_special_q;

   fp_special_t    spec;
   logic [31:0]    mul_a;
   logic [31:0]    mul_b;
   logic [31:0]    mul_p;

   assign spec   = classify_special(opa, mode);
   assign iter_d = iter_q + 1'b1;

   // One shared multiplier; the operand pair depends on which Newton step is active.
   always_comb begin
      mul_a = y_q;
      mul_b = y_q;
      case (state_q)
         ST_SQ:   begin mul_a = y_q;  mul_b = y_q; end
         ST_HX:   begin mul_a = xh_q; mul_b = t_q; end
         ST_UPD:  begin mul_a = y_q;  mul_b = t_q; end
         ST_FIN:  begin mul_a = x_q;  mul_b = y_q; end
         default: begin mul_a = y_q;  mul_b = y_q; end
      endcase
   end

   fp_mul_trunc u_mul (
      .a_i (mul_a),
      .b_i (mul_b),
      .p_o (mul_p)
   );

   // 1.5 - t. Significands carry 12 guard bits below the 24-bit mantissa so the
   // alignment shift loses little before truncation; shifts past the 36-bit
   // window contribute nothing. A zero t (exponent 0) simply leaves 1.5.
   logic [7:0]  sub_eb;
   logic [7:0]  sub_ebig;
   logic [7:0]  sub_eshift;
   logic [35:0] sub_sa;
   logic [35:0] sub_sb;
   logic [35:0] sub_big;
   logic [35:0] sub_small;
   logic [35:0] sub_aligned;
   logic [35:0] sub_mag;
   logic [35:0] sub_norm;
   logic        sub_neg;
   logic [5:0]  sub_lead;
   logic [5:0]  sub_lz;
   logic [31:0] sub_res;
   logic        unused_sub;

   always_comb begin
      sub_eb  = t_q[30:23];
      sub_sa  = {1'b1, FP_THREE_HALVES[22:0], 12'd0};
      sub_sb  = (sub_eb == 8'd0) ? 36'd0 : {1'b1, t_q[22:0], 12'd0};
      sub_neg = (sub_eb > EA) || ((sub_eb == EA) && (sub_sb > sub_sa));
      if (sub_neg) begin
         sub_big    = sub_sb;
         sub_small  = sub_sa;
         sub_ebig   = sub_eb;
         sub_eshift = sub_eb - EA;
      end else begin
         sub_big    = sub_sa;
         sub_small  = sub_sb;
         sub_ebig   = EA;
         sub_eshift = EA - sub_eb;
      end
      sub_aligned = (sub_eshift > 8'd35) ? 36'd0 : (sub_small >> sub_eshift);
      sub_mag     = sub_big - sub_aligned;
      sub_lead    = 6'd0;
      for (int i = 0; i < 36; i++) begin
         if (sub_mag[i]) sub_lead = 6'(i);
      end
      sub_lz   = 6'd35 - sub_lead;
      sub_norm = sub_mag << sub_lz;
      if ((sub_mag == 36'd0) || ({1'b0, sub_ebig} <= {3'b000, sub_lz})) begin
         sub_res = FP_ZERO;
      end else begin
         sub_res = {sub_neg, sub_ebig - {2'b00, sub_lz}, sub_norm[34:12]};
      end
   end

   assign unused_sub = ^{sub_norm[35], sub_norm[11:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         result_q      <= FP_ZERO;
         out_special_q <= 1'b0;
         iter_q        <= '0;
         x_q           <= FP_ZERO;
         xh_q          <= FP_ZERO;
         y_q           <= FP_ZERO;
         t_q           <= FP_ZERO;
         mode_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  x_q        <= opa;
                  mode_q     <= mode;
                  xh_q       <= {opa[31], opa[30:23] - 8'd1, opa[22:0]};
                  y_q        <= MAGIC - (opa >> 1);
                  iter_q     <= '0;
                  in_ready_q <= 1'b0;
                  if (spec.hit) begin
                     result_q      <= spec.value;
                     out_special_q <= 1'b1;
                     out_valid_q   <= 1'b1;
                     state_q       <= ST_DONE;
                  end else begin
                     out_special_q <= 1'b0;
                     state_q       <= ST_SQ;
                  end
               end
            end
            ST_SQ: begin
               t_q     <= mul_p;
               state_q <= ST_HX;
            end
            ST_HX: begin
               t_q     <= mul_p;
               state_q <= ST_SUB;
            end
            ST_SUB: begin
               t_q     <= sub_res;
               state_q <= ST_UPD;
            end
            ST_UPD: begin
               y_q    <= mul_p;
               iter_q <= iter_d;
               if (iter_d < ITER_MAX) begin
                  state_q <= ST_SQ;
               end else if (mode_q) begin
                  state_q <= ST_FIN;
               end else begin
                  result_q    <= mul_p;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_FIN: begin
               result_q    <= mul_p;
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign result      = result_q;
   assign out_special = out_special_q;

endmodule
